// File: rtl/flight_pkg.sv
// flight_pkg: shared constants, FSM state type and pulse-width helper for the RC PWM link
package flight_pkg;
  localparam int RC_DIV         = 50;
  localparam int RC_MIN_TICKS   = 1000;
  localparam int RC_STEP_TICKS  = 4;
  localparam int RC_FRAME_TICKS = 20000;
  localparam int PITCH          = 0;
  localparam int ROLL           = 1;
  localparam int YAW            = 2;
  localparam int THROTTLE       = 3;
  localparam int NUM_CH         = 4;
  localparam int CH_W           = 8;
  typedef enum logic {IDLE, RUN} rc_state_e;
  function automatic logic [31:0] rc_pulse_ticks(input logic [CH_W-1:0] v, input int min_t, input int step_t);
    return 32'(min_t) + 32'(v) * 32'(step_t);
  endfunction
endpackage

// File: rtl/rc_pulse_channel.sv
// rc_pulse_channel: one PWM channel holding its active byte and registering the width compare
// Ports: clk_i, rst_ni (sync, active-low); load_i copies val_i into the active byte;
// run_i/frame_cnt_i come from the shared frame timer; pwm_o is the registered PWM output.
module rc_pulse_channel import flight_pkg::*; #(
  parameter int MIN_TICKS  = RC_MIN_TICKS,
  parameter int STEP_TICKS = RC_STEP_TICKS,
  parameter int FW         = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CH_W-1:0] val_i,
  input  logic            run_i,
  input  logic [FW-1:0]   frame_cnt_i,
  output logic            pwm_o
);
  logic [CH_W-1:0] active_q, active_d;
  logic            pwm_q, pwm_d;
  // On a load cycle the compare still sees the old byte; frame_cnt is 0 then, so the output is high either way.
  always_comb begin
    active_d = load_i ? val_i : active_q;
    pwm_d    = run_i && (32'(frame_cnt_i) < rc_pulse_ticks(active_q, MIN_TICKS, STEP_TICKS));
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end
  assign pwm_o = pwm_q;
endmodule

// File: rtl/rc_pwm_encoder.sv
// rc_pwm_encoder: four-channel servo PWM encoder with frame-aligned valid/ready channel updates
// Ports: clk_i, rst_ni (sync, active-low); en_i run request; cfg_valid_i/cfg_ready_o/cfg_data_i
// update handshake ([7:0] pitch, [15:8] roll, [23:16] yaw, [31:24] throttle);
// *_pwm_o registered PWM outputs; frame_start_o one-cycle pulse on the edge all outputs rise.
module rc_pwm_encoder import flight_pkg::*; #(
  parameter int DIV         = RC_DIV,
  parameter int MIN_TICKS   = RC_MIN_TICKS,
  parameter int STEP_TICKS  = RC_STEP_TICKS,
  parameter int FRAME_TICKS = RC_FRAME_TICKS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [31:0] cfg_data_i,
  output logic        pitch_pwm_o,
  output logic        roll_pwm_o,
  output logic        yaw_pwm_o,
  output logic        throttle_pwm_o,
  output logic        frame_start_o
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int FW = $clog2(FRAME_TICKS);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
  rc_state_e   state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic        pending_q, pending_d, fs_q;
  logic        run, tick, wrap, fs, load, accept;
  logic [NUM_CH-1:0] pwm;
  assign run    = state_q == RUN;
  assign tick   = run && div_cnt_q == DIV_LAST;
  assign wrap   = tick && frame_cnt_q == FRAME_LAST;
  // Counters are held at 0 in IDLE, so the first RUN cycle is also a frame start.
  assign fs     = run && div_cnt_q == '0 && frame_cnt_q == '0;
  assign load   = fs && pending_q;
  assign accept = cfg_valid_i && !pending_q;
  always_comb begin
    state_d     = run ? ((wrap && !en_i) ? IDLE : RUN) : (en_i ? RUN : IDLE);
    div_cnt_d   = (!run || tick) ? '0 : div_cnt_q + 1'b1;
    frame_cnt_d = (!run || wrap) ? '0 : (tick ? frame_cnt_q + 1'b1 : frame_cnt_q);
    pending_d   = accept || (pending_q && !load);
    shadow_d    = accept ? cfg_data_i : shadow_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      frame_cnt_q <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      fs_q        <= fs;
    end
  end
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    rc_pulse_channel #(
      .MIN_TICKS (MIN_TICKS),
      .STEP_TICKS(STEP_TICKS),
      .FW        (FW)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (load),
      .val_i      (shadow_q[i*CH_W +: CH_W]),
      .run_i      (run),
      .frame_cnt_i(frame_cnt_q),
      .pwm_o      (pwm[i])
    );
  end
  assign cfg_ready_o    = !pending_q;
  assign frame_start_o  = fs_q;
  assign pitch_pwm_o    = pwm[PITCH];
  assign roll_pwm_o     = pwm[ROLL];
  assign yaw_pwm_o      = pwm[YAW];
  assign throttle_pwm_o = pwm[THROTTLE];
endmodule
